// File: rtl/addr_decode_cfg_stream_pkg.sv
// Shared types and constants for the runtime-configurable address decoder.
//   state_e     : commit FSM states (RUN, DRAIN, COMMIT)
//   ErrCntWidth : width of the optional decode-error counter
//   idx_width() : index width helper, never narrower than one bit
package addr_decode_cfg_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  localparam int unsigned ErrCntWidth = 16;

  function automatic int unsigned idx_width(input int unsigned num_idx);
    return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
  endfunction

endpackage

// File: rtl/addr_decode_cfg_stream_dync.sv
// addr_decode_dync: combinational address match against a rule table.
// Ports:
//   config_ongoing_i : table is being reconfigured; outputs forced to idx=0, no error
//   addr_i           : address to decode
//   rule_en_i        : per-slot enable; a disabled slot never matches
//   rule_idx_i       : per-slot target index
//   rule_start_i     : per-slot start address (NAPOT: base)
//   rule_end_i       : per-slot exclusive end, 0 = top of space (NAPOT: mask)
//   en_default_idx_i : map misses to default_idx_i instead of flagging an error
//   default_idx_i    : index returned on a miss when the default is enabled
//   idx_o            : decoded index (0 whenever dec_error_o is set)
//   dec_error_o      : no rule matched and the default is disabled
module addr_decode_dync #(
  parameter int unsigned NoRules   = 4,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned Napot     = 0,
  parameter int unsigned IdxWidth  = 2
) (
  input  logic                               config_ongoing_i,
  input  logic [AddrWidth-1:0]               addr_i,
  input  logic [NoRules-1:0]                 rule_en_i,
  input  logic [NoRules-1:0][IdxWidth-1:0]   rule_idx_i,
  input  logic [NoRules-1:0][AddrWidth-1:0]  rule_start_i,
  input  logic [NoRules-1:0][AddrWidth-1:0]  rule_end_i,
  input  logic                               en_default_idx_i,
  input  logic [IdxWidth-1:0]                default_idx_i,
  output logic [IdxWidth-1:0]                idx_o,
  output logic                               dec_error_o
);

  logic [NoRules-1:0]  match;
  logic                hit;
  logic [IdxWidth-1:0] hit_idx;

  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < NoRules; i++) begin
      if (Napot != 0) begin
        match[i] = rule_en_i[i] &&
                   (((addr_i ^ rule_start_i[i]) & rule_end_i[i]) == '0);
      end else begin
        match[i] = rule_en_i[i] && (addr_i >= rule_start_i[i]) &&
                   ((addr_i < rule_end_i[i]) || (rule_end_i[i] == '0));
      end
    end
  end

  // Ascending scan so the highest matching slot overrides lower ones.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NoRules; i++) begin
      if (match[i]) begin
        hit     = 1'b1;
        hit_idx = rule_idx_i[i];
      end
    end
  end

  always_comb begin
    idx_o       = '0;
    dec_error_o = 1'b0;
    if (!config_ongoing_i) begin
      if (hit) begin
        idx_o = hit_idx;
      end else if (en_default_idx_i) begin
        idx_o = default_idx_i;
      end else begin
        dec_error_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/addr_decode_cfg_stream.sv
// addr_decode_cfg_stream: pipelined address decoder with a double-buffered,
// software-programmable rule table.
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   req_*                  : address request stream (valid/ready)
//   rsp_*                  : registered decode response stream (valid/ready)
//   en_default_idx_i,
//   default_idx_i          : miss handling
//   cfg_we_i, cfg_sel_i,
//   cfg_en_i, cfg_idx_i,
//   cfg_start_i, cfg_end_i : shadow rule write port
//   cfg_commit_i           : request shadow-to-active swap
//   cfg_busy_o             : commit pending or in progress
//   err_cnt_o              : saturating count of error responses
//                            (present only with ADDR_DECODE_CFG_STREAM_ERRCNT_EN)
module addr_decode_cfg_stream
  import addr_decode_cfg_pkg::*;
#(
  parameter int unsigned NoIndices    = 4,
  parameter int unsigned NoRules      = 4,
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned Napot        = 0,
  parameter int unsigned IdxWidth     = idx_width(NoIndices),
  parameter int unsigned RuleSelWidth = idx_width(NoRules)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [AddrWidth-1:0]    req_addr_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [IdxWidth-1:0]     rsp_idx_o,
  output logic                    rsp_error_o,
  input  logic                    en_default_idx_i,
  input  logic [IdxWidth-1:0]     default_idx_i,
  input  logic                    cfg_we_i,
  input  logic [RuleSelWidth-1:0] cfg_sel_i,
  input  logic                    cfg_en_i,
  input  logic [IdxWidth-1:0]     cfg_idx_i,
  input  logic [AddrWidth-1:0]    cfg_start_i,
  input  logic [AddrWidth-1:0]    cfg_end_i,
  input  logic                    cfg_commit_i,
  output logic                    cfg_busy_o
`ifdef ADDR_DECODE_CFG_STREAM_ERRCNT_EN
  ,
  output logic [ErrCntWidth-1:0]  err_cnt_o
`endif
);

  typedef struct packed {
    logic [IdxWidth-1:0]  idx;
    logic [AddrWidth-1:0] start_addr;
    logic [AddrWidth-1:0] end_addr;
  } rule_t;

  state_e                 state_q, state_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [IdxWidth-1:0]    rsp_idx_q, rsp_idx_d;
  logic                   rsp_error_q, rsp_error_d;
  rule_t [NoRules-1:0]    shadow_q, shadow_d;
  rule_t [NoRules-1:0]    active_q, active_d;
  logic  [NoRules-1:0]    shadow_en_q, shadow_en_d;
  logic  [NoRules-1:0]    active_en_q, active_en_d;

  logic [NoRules-1:0][IdxWidth-1:0]  act_idx;
  logic [NoRules-1:0][AddrWidth-1:0] act_start;
  logic [NoRules-1:0][AddrWidth-1:0] act_end;
  logic [IdxWidth-1:0]               dec_idx;
  logic                              dec_error;
  logic                              req_hs;
  logic                              rsp_hs;

  assign req_ready_o = (state_q == RUN) && (!rsp_valid_q || rsp_ready_i);
  assign req_hs      = req_valid_i && req_ready_o;
  assign rsp_hs      = rsp_valid_q && rsp_ready_i;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_idx_o   = rsp_idx_q;
  assign rsp_error_o = rsp_error_q;
  assign cfg_busy_o  = (state_q != RUN);

  always_comb begin
    for (int unsigned i = 0; i < NoRules; i++) begin
      act_idx[i]   = active_q[i].idx;
      act_start[i] = active_q[i].start_addr;
      act_end[i]   = active_q[i].end_addr;
    end
  end

  // Disabled slots are masked through the enable vector: in NAPOT mode no
  // base/mask pair is guaranteed to be non-matching.
  addr_decode_dync #(
    .NoRules   (NoRules),
    .AddrWidth (AddrWidth),
    .Napot     (Napot),
    .IdxWidth  (IdxWidth)
  ) u_dec (
    .config_ongoing_i (state_q != RUN),
    .addr_i           (req_addr_i),
    .rule_en_i        (active_en_q),
    .rule_idx_i       (act_idx),
    .rule_start_i     (act_start),
    .rule_end_i       (act_end),
    .en_default_idx_i (en_default_idx_i),
    .default_idx_i    (default_idx_i),
    .idx_o            (dec_idx),
    .dec_error_o      (dec_error)
  );

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_idx_d   = rsp_idx_q;
    rsp_error_d = rsp_error_q;
    shadow_d    = shadow_q;
    shadow_en_d = shadow_en_q;
    active_d    = active_q;
    active_en_d = active_en_q;

    if (cfg_we_i && (32'(cfg_sel_i) < NoRules)) begin
      shadow_d[cfg_sel_i]    = '{idx: cfg_idx_i, start_addr: cfg_start_i, end_addr: cfg_end_i};
      shadow_en_d[cfg_sel_i] = cfg_en_i;
    end

    if (rsp_hs) begin
      rsp_valid_d = 1'b0;
    end
    if (req_hs) begin
      rsp_valid_d = 1'b1;
      rsp_idx_d   = dec_idx;
      rsp_error_d = dec_error;
    end

    unique case (state_q)
      RUN: begin
        if (cfg_commit_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (!rsp_valid_q || rsp_ready_i) state_d = COMMIT;
      end
      COMMIT: begin
        // Swap from the _d view so a same-cycle shadow write is included.
        active_d    = shadow_d;
        active_en_d = shadow_en_d;
        state_d     = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      rsp_valid_q <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_error_q <= 1'b0;
      shadow_q    <= '0;
      shadow_en_q <= '0;
      active_q    <= '0;
      active_en_q <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_error_q <= rsp_error_d;
      shadow_q    <= shadow_d;
      shadow_en_q <= shadow_en_d;
      active_q    <= active_d;
      active_en_q <= active_en_d;
    end
  end

`ifdef ADDR_DECODE_CFG_STREAM_ERRCNT_EN
  logic [ErrCntWidth-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (state_q == COMMIT) begin
      err_cnt_d = '0;
    end else if (rsp_hs && rsp_error_q && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ErrCntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_addr_decode_cfg_stream.sv
module tb_addr_decode_cfg_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_idx;
  logic        rsp_error;
  logic        en_def = 1'b0;
  logic [1:0]  def_idx = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_sel = '0;
  logic        cfg_en = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [31:0] cfg_start = '0;
  logic [31:0] cfg_end = '0;
  logic        cfg_commit = 1'b0;
  logic        cfg_busy;
`ifdef ADDR_DECODE_CFG_STREAM_ERRCNT_EN
  logic [15:0] err_cnt;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct packed {
    logic [1:0] idx;
    logic       err;
  } exp_t;
  exp_t sb[$];

  addr_decode_cfg_stream #(
    .NoIndices (4),
    .NoRules   (4),
    .AddrWidth (32),
    .Napot     (0)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_addr_i       (req_addr),
    .rsp_valid_o      (rsp_valid),
    .rsp_ready_i      (rsp_ready),
    .rsp_idx_o        (rsp_idx),
    .rsp_error_o      (rsp_error),
    .en_default_idx_i (en_def),
    .default_idx_i    (def_idx),
    .cfg_we_i         (cfg_we),
    .cfg_sel_i        (cfg_sel),
    .cfg_en_i         (cfg_en),
    .cfg_idx_i        (cfg_idx),
    .cfg_start_i      (cfg_start),
    .cfg_end_i        (cfg_end),
    .cfg_commit_i     (cfg_commit),
    .cfg_busy_o       (cfg_busy)
`ifdef ADDR_DECODE_CFG_STREAM_ERRCNT_EN
    ,
    .err_cnt_o        (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every response handshake pops one expected entry.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL rsp_unexpected: got idx=%0d err=%0b with nothing expected", rsp_idx, rsp_error);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (rsp_idx !== e.idx || rsp_error !== e.err) begin
          n_bad++;
          $display("FAIL rsp: got idx=%0d err=%0b expected idx=%0d err=%0b",
                   rsp_idx, rsp_error, e.idx, e.err);
        end
      end
    end
  end

  // Holds the request until accepted; returns how many cycles it waited.
  task automatic send(input logic [31:0] addr, input logic [1:0] eidx, input logic eerr,
                      output int unsigned waited);
    exp_t e;
    waited    = 0;
    req_valid = 1'b1;
    req_addr  = addr;
    @(negedge clk);
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      chk("req_accept_timeout", 32'(req_ready), 32'd1);
    end else begin
      e.idx = eidx;
      e.err = eerr;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic send1(input logic [31:0] addr, input logic [1:0] eidx, input logic eerr);
    int unsigned w;
    send(addr, eidx, eerr, w);
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic en, input logic [1:0] idx,
                           input logic [31:0] s, input logic [31:0] e);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_en    = en;
    cfg_idx   = idx;
    cfg_start = s;
    cfg_end   = e;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic wait_not_busy();
    int unsigned n = 0;
    @(negedge clk);
    while (cfg_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (cfg_busy) chk("commit_timeout", 32'(cfg_busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    @(posedge clk);
    #1;
    cfg_commit = 1'b0;
    wait_not_busy();
  endtask

  task automatic drain_sb();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("sb_drain", sb.size(), 32'd0);
  endtask

  initial begin
    int unsigned w0, w1, w2;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_idx", 32'(rsp_idx), 32'd0);
    chk("rst_rsp_error", 32'(rsp_error), 32'd0);
    chk("rst_cfg_busy", 32'(cfg_busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;

    // Empty table, no default: error.
    send1(32'h1000, 2'd0, 1'b0 ^ 1'b1);

    // Shadow write alone does not change decoding.
    cfg_write(2'd0, 1'b1, 2'd2, 32'h0000, 32'h2000);
    send1(32'h1000, 2'd0, 1'b1);
    commit();
    send1(32'h1000, 2'd2, 1'b0);
    send1(32'h1FFF, 2'd2, 1'b0);
    send1(32'h2000, 2'd0, 1'b1);   // end is exclusive

    // Overlap: higher slot wins.
    cfg_write(2'd1, 1'b1, 2'd3, 32'h1000, 32'h1800);
    commit();
    send1(32'h1400, 2'd3, 1'b0);
    send1(32'h1900, 2'd2, 1'b0);
    send1(32'h1800, 2'd2, 1'b0);

    // Commit while a response is stalled.
    cfg_write(2'd2, 1'b1, 2'd1, 32'h4000, 32'h5000);
    rsp_ready = 1'b0;
    send1(32'h4800, 2'd0, 1'b1);   // decoded with the old table
    cfg_commit = 1'b1;
    @(posedge clk);
    #1;
    cfg_commit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drain_busy", 32'(cfg_busy), 32'd1);
      chk("drain_req_ready", 32'(req_ready), 32'd0);
      chk("drain_rsp_hold_idx", 32'(rsp_idx), 32'd0);
      chk("drain_rsp_hold_err", 32'(rsp_error), 32'd1);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);               // response handshake, enter COMMIT
    #1;
    chk("commit_busy", 32'(cfg_busy), 32'd1);
    chk("commit_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);               // swap, back to RUN
    #1;
    chk("run_busy", 32'(cfg_busy), 32'd0);
    chk("run_req_ready", 32'(req_ready), 32'd1);
    send1(32'h4800, 2'd1, 1'b0);

    // Back-to-back with default enabled.
    en_def  = 1'b1;
    def_idx = 2'd1;
    send(32'h0000, 2'd2, 1'b0, w0);
    send(32'h1400, 2'd3, 1'b0, w1);
    send(32'h3000, 2'd1, 1'b0, w2);
    chk("b2b_stall", w0 + w1 + w2, 32'd0);

    // A disabled rule covering everything never matches.
    cfg_write(2'd3, 1'b0, 2'd1, 32'h0000, 32'h0000);
    commit();
    def_idx = 2'd3;
    send1(32'h9000, 2'd3, 1'b0);
    en_def = 1'b0;
    send1(32'h3000, 2'd0, 1'b1);
    drain_sb();

`ifdef ADDR_DECODE_CFG_STREAM_ERRCNT_EN
    commit();
    chk("errcnt_after_commit0", 32'(err_cnt), 32'd0);
    for (int i = 0; i < 3; i++) send1(32'h9000, 2'd0, 1'b1);
    drain_sb();
    chk("errcnt_three", 32'(err_cnt), 32'd3);
    commit();
    chk("errcnt_cleared", 32'(err_cnt), 32'd0);
`endif

    // Reset mid-operation drops the pending response and clears the tables.
    rsp_ready = 1'b0;
    send1(32'h1000, 2'd2, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_busy", 32'(cfg_busy), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    send1(32'h1000, 2'd0, 1'b1);
    drain_sb();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
